// File: rtl/codificador_varredura_matriz_led.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : codificador_varredura_matriz_led                                |
// | Brief  : Scan encoder that time-multiplexes a 6-LED image into pairs of  |
// |          3-bit LED codes, two LEDs per slot, repeating frames while en.  |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module codificador_varredura_matriz_led #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [5:0] pattern_in,
  output logic       A1,
  output logic       A2,
  output logic       A3,
  output logic       B1,
  output logic       B2,
  output logic       B3,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [7:0] C_HOLD_LAST = 8'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t     r_state, w_state_n;
  logic [5:0] r_shadow, r_active, r_remaining;
  logic [5:0] w_active_n, w_remaining_n;
  logic [7:0] r_counter, w_counter_n;
  logic [2:0] r_code_a, r_code_b, w_code_a_n, w_code_b_n;
  logic       r_busy, r_done, w_done_n;
  logic [5:0] w_src, w_pool, w_first, w_rest, w_second;

  function automatic logic [2:0] led_code(input logic [5:0] onehot);
    logic [2:0] code;
    case (onehot)
      6'b000001: code = 3'b001;
      6'b000010: code = 3'b011;
      6'b000100: code = 3'b100;
      6'b001000: code = 3'b101;
      6'b010000: code = 3'b110;
      6'b100000: code = 3'b111;
      default:   code = 3'b000;
    endcase
    return code;
  endfunction

  // A load coinciding with a frame end feeds the next frame directly.
  assign w_src    = load ? pattern_in : r_shadow;
  assign w_pool   = r_remaining & r_active;
  assign w_first  = w_pool & (~w_pool + 6'd1);
  assign w_rest   = w_pool & ~w_first;
  assign w_second = w_rest & (~w_rest + 6'd1);

  always_comb begin
    w_state_n     = r_state;
    w_active_n    = r_active;
    w_remaining_n = r_remaining;
    w_counter_n   = r_counter;
    w_code_a_n    = r_code_a;
    w_code_b_n    = r_code_b;
    w_done_n      = 1'b0;
    case (r_state)
      IDLE: begin
        w_code_a_n = 3'b000;
        w_code_b_n = 3'b000;
        if (en && (r_shadow != 6'd0)) begin
          w_active_n    = r_shadow;
          w_remaining_n = r_shadow;
          w_state_n     = PICK;
        end
      end
      PICK: begin
        w_code_a_n    = led_code(w_first);
        w_code_b_n    = led_code(w_second);
        w_remaining_n = w_rest & ~w_second;
        w_counter_n   = C_HOLD_LAST;
        w_state_n     = HOLD;
      end
      HOLD: begin
        if (r_counter != 8'd0) begin
          w_counter_n = r_counter - 8'd1;
        end else if (r_remaining != 6'd0) begin
          w_code_a_n = 3'b000;
          w_code_b_n = 3'b000;
          w_state_n  = PICK;
        end else begin
          w_code_a_n = 3'b000;
          w_code_b_n = 3'b000;
          w_done_n   = 1'b1;
          if (en && (w_src != 6'd0)) begin
            w_active_n    = w_src;
            w_remaining_n = w_src;
            w_state_n     = PICK;
          end else begin
            w_state_n = IDLE;
          end
        end
      end
      default: begin
        w_code_a_n = 3'b000;
        w_code_b_n = 3'b000;
        w_state_n  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shadow    <= 6'd0;
      r_active    <= 6'd0;
      r_remaining <= 6'd0;
      r_counter   <= 8'd0;
      r_code_a    <= 3'b000;
      r_code_b    <= 3'b000;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (load) begin
        r_shadow <= pattern_in;
      end
      r_state     <= w_state_n;
      r_active    <= w_active_n;
      r_remaining <= w_remaining_n;
      r_counter   <= w_counter_n;
      r_code_a    <= w_code_a_n;
      r_code_b    <= w_code_b_n;
      r_busy      <= (w_state_n != IDLE);
      r_done      <= w_done_n;
    end
  end

  assign {A1, A2, A3} = r_code_a;
  assign {B1, B2, B3} = r_code_b;
  assign busy         = r_busy;
  assign frame_done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_codificador_varredura_matriz_led.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_codificador_varredura_matriz_led                             |
// | Brief  : Directed self-checking bench for the LED matrix scan encoder.   |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module tb_codificador_varredura_matriz_led;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [5:0] pattern_in = 6'd0;
  logic       A1, A2, A3, B1, B2, B3, busy, frame_done;
  logic [2:0] w_code_a, w_code_b;

  int checks = 0;
  int errors = 0;

  codificador_varredura_matriz_led #(.DWELL(DWELL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .pattern_in (pattern_in),
    .A1         (A1),
    .A2         (A2),
    .A3         (A3),
    .B1         (B1),
    .B2         (B2),
    .B3         (B3),
    .busy       (busy),
    .frame_done (frame_done)
  );

  assign w_code_a = {A1, A2, A3};
  assign w_code_b = {B1, B2, B3};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_a"},    8'(w_code_a), 8'h0);
    check({tag, "_b"},    8'(w_code_b), 8'h0);
    check({tag, "_busy"}, 8'(busy), 8'h0);
    check({tag, "_done"}, 8'(frame_done), 8'h0);
  endtask

  // One slot: a blank PICK cycle followed by DWELL lit cycles.
  task automatic run_slot(input string tag, input logic [2:0] a, input logic [2:0] b,
                          input logic done_at_pick);
    tick();
    load = 1'b0;
    check({tag, "_blank_a"},    8'(w_code_a), 8'h0);
    check({tag, "_blank_b"},    8'(w_code_b), 8'h0);
    check({tag, "_blank_busy"}, 8'(busy), 8'h1);
    check({tag, "_blank_done"}, 8'(frame_done), 8'(done_at_pick));
    repeat (DWELL) begin
      tick();
      check({tag, "_a"},    8'(w_code_a), 8'(a));
      check({tag, "_b"},    8'(w_code_b), 8'(b));
      check({tag, "_done"}, 8'(frame_done), 8'h0);
      check({tag, "_busy"}, 8'(busy), 8'h1);
    end
  endtask

  initial begin
    repeat (3) tick();
    check_quiet("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full image: three slots, repeating frames every 15 cycles.
    pattern_in = 6'b111111;
    load = 1'b1;
    en = 1'b1;
    tick();
    load = 1'b0;
    check("idle_after_load_busy", 8'(busy), 8'h0);
    run_slot("f1s1", 3'b001, 3'b011, 1'b0);
    run_slot("f1s2", 3'b100, 3'b101, 1'b0);
    run_slot("f1s3", 3'b110, 3'b111, 1'b0);
    run_slot("f2s1", 3'b001, 3'b011, 1'b1);

    // Mid-frame load only takes effect on the next frame.
    pattern_in = 6'b100001;
    load = 1'b1;
    run_slot("f2s2", 3'b100, 3'b101, 1'b0);
    run_slot("f2s3", 3'b110, 3'b111, 1'b0);
    run_slot("f3s1", 3'b001, 3'b111, 1'b1);
    run_slot("f4s1", 3'b001, 3'b111, 1'b1);

    // Load at the frame boundary bypasses the shadow; odd popcount blanks B.
    pattern_in = 6'b000100;
    load = 1'b1;
    run_slot("f5s1", 3'b100, 3'b000, 1'b1);
    run_slot("f6s1", 3'b100, 3'b000, 1'b1);

    // Dropping en mid-frame still finishes the frame.
    pattern_in = 6'b111111;
    load = 1'b1;
    run_slot("f7s1", 3'b001, 3'b011, 1'b1);
    en = 1'b0;
    run_slot("f7s2", 3'b100, 3'b101, 1'b0);
    run_slot("f7s3", 3'b110, 3'b111, 1'b0);
    tick();
    check("end_done", 8'(frame_done), 8'h1);
    check("end_busy", 8'(busy), 8'h0);
    check("end_a", 8'(w_code_a), 8'h0);
    check("end_b", 8'(w_code_b), 8'h0);
    tick();
    check_quiet("idle");

    // Asynchronous reset in the middle of a HOLD.
    en = 1'b1;
    run_slot("r1s1", 3'b001, 3'b011, 1'b0);
    tick();
    tick();
    check("pre_rst_a", 8'(w_code_a), 8'h4);
    check("pre_rst_busy", 8'(busy), 8'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Empty image never starts a frame.
    pattern_in = 6'b000000;
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (12) begin
      tick();
      check_quiet("empty");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
